// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg
// Shared definitions for the MEM-stage sequencer and its timeout counter.
//   mem_state_t         - sequencer state encoding (IDLE / ACCESS / DONE)
//   MEM_TIMEOUT_DEFAULT - default number of ACCESS cycles before an abort
//   TIMEOUT_CNT_W       - width of the timeout counter
package mem_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_t;

    localparam int MEM_TIMEOUT_DEFAULT = 16;
    localparam int TIMEOUT_CNT_W       = 8;

endpackage

// File: rtl/mem_stage_ctrl_timeout_cnt.sv
// mem_timeout_cnt
// Counts ACCESS cycles that end without an acknowledge and flags the cycle
// in which the LIMIT-th such cycle is running, so the sequencer can abort
// on that same edge.
// Ports:
//   clk     in  clock
//   reset   in  synchronous, active-high reset
//   clear   in  restart the count (asserted on entry to ACCESS)
//   enable  in  this is an ACCESS cycle without acknowledge
//   expired out the current enabled cycle is the LIMIT-th one
module mem_timeout_cnt
    import mem_stage_ctrl_pkg::*;
#(
    parameter int LIMIT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMEOUT_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // The count holds the number of completed wait cycles, so the LIMIT-th
    // wait cycle is the one that sees LIMIT-1.
    assign expired = enable && (count == TIMEOUT_CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// MEM-stage sequencer: turns the EX/MEM memory-control bits into a req/ack
// transaction with a multi-cycle data memory, stalls the pipeline and feeds
// bubbles into MEM/WB while the access is outstanding, and presents load
// data to MEM/WB for the single advancing DONE cycle.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that get no ack
// within TIMEOUT_CYCLES ACCESS cycles (rdata forced to 0, bus_err sticky).
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   mem_read, mem_write    memory-control bits from EX/MEM
//   addr, wdata            address and store data from EX/MEM
//   dmem_req/we/addr/wdata request side of the data-memory handshake
//   dmem_ack, dmem_rdata   completion pulse and read data
//   rdata                  registered load data to MEM/WB
//   stall, wb_bubble       pipeline hold and MEM/WB NOP injection
//   bus_err                sticky timeout flag (0 without MEM_TIMEOUT_EN)
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        wb_bubble,
    output logic        bus_err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_stage_ctrl: TIMEOUT_CYCLES must be in 1..255");
    end

    mem_state_t  state;
    mem_state_t  state_next;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        access_req;
    logic        start_access;
    logic        in_access;
    logic        timeout;

    assign access_req   = mem_read | mem_write;
    assign start_access = (state == ST_IDLE) && access_req;
    assign in_access    = (state == ST_ACCESS);

`ifdef MEM_TIMEOUT_EN
    logic bus_err_q;

    mem_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_access),
        .enable  (in_access && !dmem_ack),
        .expired (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err_q <= 1'b0;
        end else if (timeout) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    // State register plus the request latch. The request is captured in the
    // IDLE cycle that starts it, so the memory sees stable values for the
    // whole ACCESS window even if EX/MEM later changes. A write wins when both
    // control bits are set because we simply take mem_write as the direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            if (start_access) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                we_q    <= mem_write;
            end
            if (in_access) begin
                if (dmem_ack) begin
                    if (!we_q) begin
                        rdata_q <= dmem_rdata;
                    end
                end else if (timeout) begin
                    rdata_q <= '0;
                end
            end
        end
    end

    // Next state and handshake outputs. The IDLE stall is combinational so a
    // memory instruction is held in the very cycle it is first seen.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        dmem_req   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (access_req) begin
                    stall      = 1'b1;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                stall    = 1'b1;
                dmem_req = 1'b1;
                if (dmem_ack || timeout) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign wb_bubble  = stall;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl
// Directed bench for mem_stage_ctrl. Inputs change 1 ns after each rising
// edge; outputs are compared on the following falling edge. The timeout
// scenarios run when MEM_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 4); the
// default build instead checks that ACCESS waits indefinitely.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] rdata;
    logic        stall;
    logic        wb_bubble;
    logic        bus_err;

    int check_count;
    int error_count;

    mem_stage_ctrl #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .wdata      (wdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .rdata      (rdata),
        .stall      (stall),
        .wb_bubble  (wb_bubble),
        .bus_err    (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s got %h want %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then wait for the
    // falling edge where the caller compares outputs.
    task automatic applyStimulus(input logic rst, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic ack, input logic [31:0] ack_data);
        @(posedge clk);
        #1;
        reset      = rst;
        mem_read   = rd;
        mem_write  = wr;
        addr       = a;
        wdata      = wd;
        dmem_ack   = ack;
        dmem_rdata = ack_data;
        @(negedge clk);
    endtask

    task automatic checkHold(input string tag, input logic exp_stall, input logic exp_req);
        checkOutput({tag, "_stall"}, 32'(stall), 32'(exp_stall));
        checkOutput({tag, "_bubble"}, 32'(wb_bubble), 32'(exp_stall));
        checkOutput({tag, "_req"}, 32'(dmem_req), 32'(exp_req));
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        reset       = 1'b1;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        addr        = '0;
        wdata       = '0;
        dmem_ack    = 1'b0;
        dmem_rdata  = '0;

        // Reset values
        @(negedge clk);
        checkHold("rst", 1'b0, 1'b0);
        checkOutput("rst_we", 32'(dmem_we), 32'h0);
        checkOutput("rst_addr", dmem_addr, 32'h0);
        checkOutput("rst_wdata", dmem_wdata, 32'h0);
        checkOutput("rst_rdata", rdata, 32'h0);
        checkOutput("rst_buserr", 32'(bus_err), 32'h0);

        // Load with ack in the first ACCESS cycle
        applyStimulus(0, 1, 0, 32'h100, 32'h0, 0, 32'h0);
        checkHold("ld_idle", 1'b1, 1'b0);
        applyStimulus(0, 1, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF);
        checkHold("ld_acc", 1'b1, 1'b1);
        checkOutput("ld_we", 32'(dmem_we), 32'h0);
        checkOutput("ld_addr", dmem_addr, 32'h100);
        applyStimulus(0, 1, 0, 32'h100, 32'h0, 0, 32'h0);
        checkHold("ld_done", 1'b0, 1'b0);
        checkOutput("ld_rdata", rdata, 32'hDEADBEEF);

        // Store with three wait cycles; ack on the 4th ACCESS cycle
        applyStimulus(0, 0, 1, 32'h200, 32'h12345678, 0, 32'h0);
        checkHold("st_idle", 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 1, 32'h200, (i == 1) ? 32'h12345678 : 32'hFFFF0000,
                          (i == 4), 32'hBAD0BAD0);
            checkHold("st_acc", 1'b1, 1'b1);
            checkOutput("st_we", 32'(dmem_we), 32'h1);
            checkOutput("st_wdata", dmem_wdata, 32'h12345678);
            checkOutput("st_addr", dmem_addr, 32'h200);
        end
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkHold("st_done", 1'b0, 1'b0);
        checkOutput("st_rdata", rdata, 32'hDEADBEEF);

        // Back-to-back loads with stray acks around the boundary
        applyStimulus(0, 1, 0, 32'h300, 32'h0, 0, 32'h0);
        checkHold("b2b1_idle", 1'b1, 1'b0);
        applyStimulus(0, 1, 0, 32'h300, 32'h0, 0, 32'h0);
        checkHold("b2b1_acc1", 1'b1, 1'b1);
        applyStimulus(0, 1, 0, 32'h300, 32'h0, 1, 32'h11111111);
        checkHold("b2b1_acc2", 1'b1, 1'b1);
        applyStimulus(0, 1, 0, 32'h300, 32'h0, 1, 32'h99999999);
        checkHold("b2b1_done", 1'b0, 1'b0);
        checkOutput("b2b1_rdata", rdata, 32'h11111111);
        applyStimulus(0, 1, 0, 32'h304, 32'h0, 1, 32'h99999999);
        checkHold("b2b2_idle", 1'b1, 1'b0);
        checkOutput("b2b2_done_ack_ignored", rdata, 32'h11111111);
        applyStimulus(0, 1, 0, 32'h304, 32'h0, 0, 32'h33333333);
        checkHold("b2b2_acc1", 1'b1, 1'b1);
        checkOutput("b2b2_addr", dmem_addr, 32'h304);
        checkOutput("b2b2_idle_ack_ignored", rdata, 32'h11111111);
        applyStimulus(0, 1, 0, 32'h304, 32'h0, 1, 32'h22222222);
        checkHold("b2b2_acc2", 1'b1, 1'b1);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkHold("b2b2_done", 1'b0, 1'b0);
        checkOutput("b2b2_rdata", rdata, 32'h22222222);

        // Reset on the 2nd ACCESS cycle
        applyStimulus(0, 1, 0, 32'h400, 32'h0, 0, 32'h0);
        checkHold("rmid_idle", 1'b1, 1'b0);
        applyStimulus(0, 1, 0, 32'h400, 32'h0, 0, 32'h0);
        checkHold("rmid_acc1", 1'b1, 1'b1);
        applyStimulus(1, 1, 0, 32'h400, 32'h0, 0, 32'h0);
        checkHold("rmid_acc2", 1'b1, 1'b1);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 32'h55555555);
        checkHold("rmid_after", 1'b0, 1'b0);
        checkOutput("rmid_we", 32'(dmem_we), 32'h0);
        checkOutput("rmid_addr", dmem_addr, 32'h0);
        checkOutput("rmid_rdata", rdata, 32'h0);
        checkOutput("rmid_buserr", 32'(bus_err), 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 32'h66666666);
        checkOutput("rmid_late_ack", rdata, 32'h0);

`ifdef MEM_TIMEOUT_EN
        // Clean load so the abort has something to clear
        applyStimulus(0, 1, 0, 32'h500, 32'h0, 0, 32'h0);
        applyStimulus(0, 1, 0, 32'h500, 32'h0, 1, 32'hA5A5A5A5);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkOutput("to_pre_rdata", rdata, 32'hA5A5A5A5);

        // Ack arriving in the cycle the limit is reached wins
        applyStimulus(0, 1, 0, 32'h510, 32'h0, 0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 1, 0, 32'h510, 32'h0, (i == 4), 32'h77777777);
            checkHold("to_tie_acc", 1'b1, 1'b1);
        end
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkHold("to_tie_done", 1'b0, 1'b0);
        checkOutput("to_tie_rdata", rdata, 32'h77777777);
        checkOutput("to_tie_buserr", 32'(bus_err), 32'h0);

        // No ack at all: abort after 4 ACCESS cycles
        applyStimulus(0, 1, 0, 32'h600, 32'h0, 0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 1, 0, 32'h600, 32'h0, 0, 32'h0);
            checkHold("to_acc", 1'b1, 1'b1);
        end
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkHold("to_done", 1'b0, 1'b0);
        checkOutput("to_rdata", rdata, 32'h0);
        checkOutput("to_buserr", 32'(bus_err), 32'h1);

        // bus_err stays set through a later clean access
        applyStimulus(0, 1, 0, 32'h700, 32'h0, 0, 32'h0);
        applyStimulus(0, 1, 0, 32'h700, 32'h0, 1, 32'h88888888);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkOutput("to_clean_rdata", rdata, 32'h88888888);
        checkOutput("to_sticky_buserr", 32'(bus_err), 32'h1);
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkOutput("to_reset_buserr", 32'(bus_err), 32'h0);
`else
        // Without the timeout ACCESS simply keeps waiting
        applyStimulus(0, 1, 0, 32'h600, 32'h0, 0, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(0, 1, 0, 32'h600, 32'h0, 0, 32'h0);
        end
        checkHold("wait_acc20", 1'b1, 1'b1);
        checkOutput("wait_buserr", 32'(bus_err), 32'h0);
        applyStimulus(0, 1, 0, 32'h600, 32'h0, 1, 32'h0F0F0F0F);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkHold("wait_done", 1'b0, 1'b0);
        checkOutput("wait_rdata", rdata, 32'h0F0F0F0F);
`endif

        // Load a known value, then 10 cycles of non-memory traffic with
        // stray acks that must not disturb rdata
        applyStimulus(0, 1, 0, 32'h800, 32'h0, 0, 32'h0);
        applyStimulus(0, 1, 0, 32'h800, 32'h0, 1, 32'h13579BDF);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 32'(i * 4), 32'(i), (i % 3 == 0), 32'hC0DE0000 | 32'(i));
            checkHold("nomem", 1'b0, 1'b0);
            checkOutput("nomem_rdata", rdata, 32'h13579BDF);
        end

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
